// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: shared key map, column drive patterns, scan FSM encodings
// and the PicoBlaze port numbers used by the keypad block.
package keypad_scanner_pkg;
   localparam logic [1:0] S_SETTLE = 2'd0;
   localparam logic [1:0] S_SAMPLE = 2'd1;
   localparam logic [1:0] S_EVAL   = 2'd2;
   localparam logic [3:0] COL0_DRIVE = 4'b1110;
   localparam logic [3:0] COL1_DRIVE = 4'b1101;
   localparam logic [3:0] COL2_DRIVE = 4'b1011;
   localparam logic [3:0] COL3_DRIVE = 4'b0111;
   localparam logic [7:0] KEY_CODE_PORT   = 8'h00;
   localparam logic [7:0] KEY_STATUS_PORT = 8'h01;
   // Nibble i holds the key at index 4*col+row.
   localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

   function automatic logic [3:0] col_drive(input logic [1:0] c);
      return c == 2'd0 ? COL0_DRIVE : c == 2'd1 ? COL1_DRIVE : c == 2'd2 ? COL2_DRIVE : COL3_DRIVE;
   endfunction

   function automatic logic [3:0] key_value(input logic [3:0] idx);
      return KEY_MAP[{idx, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--)
         if (v[i]) idx = 4'(i);
      return idx;
   endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key queue handshake between the scanner and the host input-port mux.
interface keypad_scanner_if;
   logic [7:0] key_code;
   logic       key_valid;
   logic       key_ack;
   logic       key_overflow;
   logic       ovf_clear;
   logic       key_held;
   modport slave  (output key_code, key_valid, key_overflow, key_held, input key_ack, ovf_clear);
   modport master (input key_code, key_valid, key_overflow, key_held, output key_ack, ovf_clear);
endinterface

// File: rtl/keypad_scanner_fifo.sv
// key_fifo: 4-entry x 4-bit queue; simultaneous push and pop always both take
// effect, even when empty (the pushed value passes straight through).
module key_fifo (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [3:0] din_i,
   output logic       full_o,
   output logic       empty_o,
   output logic [3:0] head_o
);
   logic [3:0] mem_q [4];
   logic [1:0] wp_q, rp_q;
   logic [2:0] cnt_q;
   logic       do_push, do_pop;

   assign full_o  = cnt_q == 3'd4;
   assign empty_o = cnt_q == 3'd0;
   assign head_o  = mem_q[rp_q];
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & (~empty_o | push_i);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) mem_q[wp_q] <= din_i;
         wp_q  <= wp_q + {1'b0, do_push};
         rp_q  <= rp_q + {1'b0, do_pop};
         cnt_q <= cnt_q + {2'b00, do_push} - {2'b00, do_pop};
      end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobed 4x4 keypad scan with sweep-level debounce,
// feeding newly pressed keys into a small queue for the host.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_TICKS     = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic              OSC_100MHz,
   input  logic              RST,
   output logic [3:0]        KYPD_COL,
   input  logic [3:0]        KYPD_ROW,
   keypad_scanner_if.slave   host
);
   localparam int TW = $clog2(SCAN_TICKS + 1);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   logic [3:0]    row_s1_q, row_sync_q, kypd_col_q, head, push_code;
   logic [1:0]    state_q, state_d, col_q, col_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [CW-1:0] stable_q, stable_d;
   logic [15:0]   frame_q, frame_d, last_q, debounced_q, debounced_d, new_keys;
   logic          held_q, ovf_q, push, full, empty;

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      tick_d      = tick_q;
      frame_d     = frame_q;
      stable_d    = stable_q;
      debounced_d = debounced_q;
      new_keys    = '0;
      case (state_q)
         S_SETTLE: begin
            tick_d  = tick_q == TW'(SCAN_TICKS - 1) ? '0 : tick_q + 1'b1;
            state_d = tick_q == TW'(SCAN_TICKS - 1) ? S_SAMPLE : S_SETTLE;
         end
         S_SAMPLE: begin
            frame_d[{col_q, 2'b00} +: 4] = ~row_sync_q;
            state_d = col_q == 2'd3 ? S_EVAL : S_SETTLE;
            col_d   = col_q == 2'd3 ? col_q : col_q + 1'b1;
         end
         S_EVAL: begin
            stable_d = frame_q != last_q ? CW'(1) :
                       stable_q == CW'(DEBOUNCE_SCANS) ? stable_q : stable_q + 1'b1;
            if (stable_d == CW'(DEBOUNCE_SCANS) && frame_q != debounced_q) begin
               new_keys    = frame_q & ~debounced_q;
               debounced_d = frame_q;
            end
            col_d   = '0;
            state_d = S_SETTLE;
         end
         default: state_d = S_SETTLE;
      endcase
   end

   // Only the lowest newly pressed key is queued; there is no rollover.
   assign push      = |new_keys;
   assign push_code = key_value(lowest_set(new_keys));

   always_ff @(posedge OSC_100MHz or negedge RST)
      if (!RST) begin
         row_s1_q    <= '1;
         row_sync_q  <= '1;
         state_q     <= S_SETTLE;
         col_q       <= '0;
         tick_q      <= '0;
         frame_q     <= '0;
         last_q      <= '0;
         stable_q    <= '0;
         debounced_q <= '0;
         kypd_col_q  <= COL0_DRIVE;
         held_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         row_s1_q    <= KYPD_ROW;
         row_sync_q  <= row_s1_q;
         state_q     <= state_d;
         col_q       <= col_d;
         tick_q      <= tick_d;
         frame_q     <= frame_d;
         last_q      <= state_q == S_EVAL ? frame_q : last_q;
         stable_q    <= stable_d;
         debounced_q <= debounced_d;
         kypd_col_q  <= col_drive(col_d);
         held_q      <= |debounced_q;
         ovf_q       <= (push & full & ~host.key_ack) | (ovf_q & ~host.ovf_clear);
      end

   key_fifo u_fifo (
      .clk    (OSC_100MHz),
      .rst_n  (RST),
      .push_i (push),
      .pop_i  (host.key_ack),
      .din_i  (push_code),
      .full_o (full),
      .empty_o(empty),
      .head_o (head)
   );

   assign KYPD_COL          = kypd_col_q;
   assign host.key_valid    = ~empty;
   assign host.key_code     = empty ? 8'h00 : {4'h0, head};
   assign host.key_overflow = ovf_q;
   assign host.key_held     = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad row model plus a scoreboard of expected key codes
// checked as the host pops the queue.
module tb_keypad_scanner;
   localparam int ST    = 4;
   localparam int DS    = 2;
   localparam int SWEEP = 4 * (ST + 1) + 1;
   localparam int HOLD  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  col, row;
   logic [15:0] pressed = '0;
   logic [7:0]  exp_q[$];
   logic        exp_ovf = 1'b0;
   logic [3:0]  kv [16] = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                            4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};
   int          checks = 0;
   int          failures = 0;

   keypad_scanner_if bus ();

   keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
      .OSC_100MHz(clk),
      .RST       (rst_n),
      .KYPD_COL  (col),
      .KYPD_ROW  (row),
      .host      (bus)
   );

   always #5 clk = ~clk;

   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[4*c+r] && !col[c]) row[r] = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_push(input logic [7:0] v);
      if (exp_q.size() < 4) exp_q.push_back(v);
      else exp_ovf = 1'b1;
   endtask

   task automatic tap(input int idx);
      pressed = 16'(1) << idx;
      cycles(HOLD * SWEEP);
      model_push({4'h0, kv[idx]});
      pressed = '0;
      cycles(HOLD * SWEEP);
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] e;
      int n = 0;
      while (!bus.key_valid && n < 6 * SWEEP) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, bus.key_valid, 1);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hEE;
      chk(tag, bus.key_code, e);
      bus.key_ack = 1'b1;
      @(negedge clk);
      bus.key_ack = 1'b0;
   endtask

   // Leaves the bench at the negedge inside the EVAL cycle of the current sweep.
   task automatic wait_eval();
      int n = 0;
      while (col == 4'b0111 && n < 4 * SWEEP) begin @(negedge clk); n++; end
      while (col != 4'b0111 && n < 4 * SWEEP) begin @(negedge clk); n++; end
      if (n >= 4 * SWEEP) chk("sync_timeout", 0, 1);
      cycles(5);
   endtask

   initial begin
      bus.key_ack   = 1'b0;
      bus.ovf_clear = 1'b0;
      cycles(3);
      chk("rst_col", col, 4'b1110);
      chk("rst_valid", bus.key_valid, 0);
      chk("rst_code", bus.key_code, 8'h00);
      chk("rst_ovf", bus.key_overflow, 0);
      chk("rst_held", bus.key_held, 0);
      rst_n = 1'b1;

      pressed = 16'(1) << 5;
      cycles(2 * SWEEP + 10);
      chk("pre_rst_valid", bus.key_valid, 1);
      rst_n = 1'b0;
      cycles(2);
      chk("mid_rst_col", col, 4'b1110);
      chk("mid_rst_valid", bus.key_valid, 0);
      chk("mid_rst_code", bus.key_code, 8'h00);
      rst_n = 1'b1;
      cycles(SWEEP + 10);
      chk("post_rst_nodebounce", bus.key_valid, 0);
      model_push(8'h05);
      cycles(SWEEP);
      chk("t2_held", bus.key_held, 1);
      pop_check("t2_5");
      chk("t2_ack_valid", bus.key_valid, 0);
      chk("t2_ack_code", bus.key_code, 8'h00);
      pressed = '0;
      cycles(HOLD * SWEEP);
      chk("t2_release_held", bus.key_held, 0);

      for (int i = 0; i < 6; i++) begin
         pressed = i % 2 == 0 ? 16'(1) << 10 : '0;
         cycles(SWEEP);
         chk("t3_bounce_held", bus.key_held, 0);
      end
      pressed = '0;
      cycles(HOLD * SWEEP);
      chk("t3_valid", bus.key_valid, 0);

      foreach (kv[i]) if (i == 0 || i == 4 || i == 8 || i == 1 || i == 5) tap(i);
      chk("t4_ovf", bus.key_overflow, exp_ovf);
      for (int i = 0; i < 4; i++) pop_check("t4_pop");
      chk("t4_empty", bus.key_valid, 0);
      bus.ovf_clear = 1'b1;
      @(negedge clk);
      bus.ovf_clear = 1'b0;
      exp_ovf = 1'b0;
      chk("t4_ovf_clr", bus.key_overflow, exp_ovf);

      pressed = 16'h1001;
      cycles(HOLD * SWEEP);
      model_push(8'h01);
      chk("t5_held_on", bus.key_held, 1);
      pressed = '0;
      cycles(HOLD * SWEEP);
      chk("t5_held_off", bus.key_held, 0);
      pop_check("t5_1");
      chk("t5_single", bus.key_valid, 0);

      tap(0); tap(4); tap(8); tap(1);
      chk("t6_full_ovf", bus.key_overflow, 0);
      wait_eval();
      @(negedge clk);
      pressed = 16'(1) << 9;
      wait_eval();
      wait_eval();
      chk("t6_head", bus.key_code, exp_q[0]);
      bus.key_ack = 1'b1;
      @(negedge clk);
      bus.key_ack = 1'b0;
      void'(exp_q.pop_front());
      model_push(8'h06);
      chk("t6_ovf", bus.key_overflow, exp_ovf);
      pressed = '0;
      cycles(HOLD * SWEEP);
      for (int i = 0; i < 4; i++) pop_check("t6_pop");
      chk("t6_empty", bus.key_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
